// File: rtl/video_dram_slotter.sv
// Per-slot DRAM arbiter: video gets a per-window quota of slots (from video_bw), CPU takes the rest.
// Latency: one registered command per dram_stb. CPU waits while video holds quota and has pending fetches.
module video_dram_slotter #(
   parameter int AW   = 21,
   parameter int DW   = 16,
   parameter int PEND = 7
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          dram_stb_i,
   input  logic          line_start_i,
   input  logic          vid_go_i,
   input  logic [4:0]    video_bw_i,
   input  logic          vid_req_i,
   input  logic [AW-1:0] video_addr_i,
   input  logic          cpu_req_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic          cpu_rnw_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic          dram_req_o,
   output logic [AW-1:0] dram_addr_o,
   output logic          dram_rnw_o,
   output logic [DW-1:0] dram_wdata_o,
   output logic          dram_vid_o,
   output logic          vid_next_o,
   output logic          cpu_ack_o,
   output logic          vid_late_o
);

   localparam logic [2:0] PEND_MAX = 3'(PEND);

   logic [2:0]    win_cnt_q,  win_cnt_d;
   logic [1:0]    win_size_q, win_size_d;
   logic [2:0]    quota_q,    quota_d;
   logic [2:0]    vid_pend_q, vid_pend_d;
   logic          dram_req_q, dram_req_d;
   logic [AW-1:0] dram_addr_q, dram_addr_d;
   logic          dram_rnw_q, dram_rnw_d;
   logic [DW-1:0] dram_wdata_q, dram_wdata_d;
   logic          dram_vid_q, dram_vid_d;
   logic          vid_next_q, vid_next_d;
   logic          cpu_ack_q,  cpu_ack_d;
   logic          vid_late_q, vid_late_d;

   logic          win_start;
   logic          last_slot;
   logic [1:0]    cur_size;
   logic [2:0]    quota_eff;
   logic          grant_vid;
   logic          grant_cpu;

   // Highest set bit of the one-hot quota field wins.
   function automatic logic [2:0] quota_of(input logic [2:0] q);
      if (q[2])      return 3'd4;
      else if (q[1]) return 3'd2;
      else if (q[0]) return 3'd1;
      else           return 3'd0;
   endfunction

   function automatic logic [2:0] last_idx(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd3;
         default: return 3'd7;
      endcase
   endfunction

   always_comb begin
      win_start = dram_stb_i && (win_cnt_q == 3'd0);
      cur_size  = win_start ? video_bw_i[4:3] : win_size_q;
      last_slot = dram_stb_i && (win_cnt_q == last_idx(cur_size));
      quota_eff = win_start ? quota_of(video_bw_i[2:0]) : quota_q;
      grant_vid = dram_stb_i && vid_go_i && (vid_pend_q != 3'd0) && (quota_eff != 3'd0);
      grant_cpu = dram_stb_i && !grant_vid && cpu_req_i;
   end

   always_comb begin
      win_cnt_d  = win_cnt_q;
      win_size_d = win_size_q;
      quota_d    = quota_q;
      vid_pend_d = vid_pend_q;

      if (win_start) win_size_d = video_bw_i[4:3];
      if (dram_stb_i) begin
         win_cnt_d = last_slot ? 3'd0 : win_cnt_q + 3'd1;
         quota_d   = quota_eff - {2'b00, grant_vid};
      end

      case ({vid_req_i, grant_vid})
         2'b10:   if (vid_pend_q != PEND_MAX) vid_pend_d = vid_pend_q + 3'd1;
         2'b01:   vid_pend_d = vid_pend_q - 3'd1;
         default: vid_pend_d = vid_pend_q;
      endcase

      if (line_start_i) begin
         win_cnt_d  = 3'd0;
         quota_d    = 3'd0;
         vid_pend_d = 3'd0;
      end
   end

   always_comb begin
      dram_req_d   = dram_req_q;
      dram_addr_d  = dram_addr_q;
      dram_rnw_d   = dram_rnw_q;
      dram_wdata_d = dram_wdata_q;
      dram_vid_d   = dram_vid_q;
      vid_next_d   = grant_vid;
      cpu_ack_d    = grant_cpu;
      vid_late_d   = last_slot && vid_go_i && (vid_pend_d != 3'd0);

      if (dram_stb_i) begin
         dram_req_d = grant_vid || grant_cpu;
         dram_vid_d = grant_vid;
         if (grant_vid) begin
            dram_addr_d = video_addr_i;
            dram_rnw_d  = 1'b1;
         end else if (grant_cpu) begin
            dram_addr_d  = cpu_addr_i;
            dram_rnw_d   = cpu_rnw_i;
            dram_wdata_d = cpu_wdata_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         win_cnt_q    <= '0;
         win_size_q   <= '0;
         quota_q      <= '0;
         vid_pend_q   <= '0;
         dram_req_q   <= 1'b0;
         dram_addr_q  <= '0;
         dram_rnw_q   <= 1'b0;
         dram_wdata_q <= '0;
         dram_vid_q   <= 1'b0;
         vid_next_q   <= 1'b0;
         cpu_ack_q    <= 1'b0;
         vid_late_q   <= 1'b0;
      end else begin
         win_cnt_q    <= win_cnt_d;
         win_size_q   <= win_size_d;
         quota_q      <= quota_d;
         vid_pend_q   <= vid_pend_d;
         dram_req_q   <= dram_req_d;
         dram_addr_q  <= dram_addr_d;
         dram_rnw_q   <= dram_rnw_d;
         dram_wdata_q <= dram_wdata_d;
         dram_vid_q   <= dram_vid_d;
         vid_next_q   <= vid_next_d;
         cpu_ack_q    <= cpu_ack_d;
         vid_late_q   <= vid_late_d;
      end
   end

   assign dram_req_o   = dram_req_q;
   assign dram_addr_o  = dram_addr_q;
   assign dram_rnw_o   = dram_rnw_q;
   assign dram_wdata_o = dram_wdata_q;
   assign dram_vid_o   = dram_vid_q;
   assign vid_next_o   = vid_next_q;
   assign cpu_ack_o    = cpu_ack_q;
   assign vid_late_o   = vid_late_q;

endmodule

// File: tb/tb_video_dram_slotter.sv
// Directed bench for video_dram_slotter: one dram_stb every 3 clocks, outputs sampled on negedge.
module tb_video_dram_slotter;

   localparam int AW = 21;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst, dram_stb, line_start, vid_go, vid_req, cpu_req, cpu_rnw;
   logic [4:0]    video_bw;
   logic [AW-1:0] video_addr, cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          dram_req, dram_rnw, dram_vid, vid_next, cpu_ack, vid_late;
   logic [AW-1:0] dram_addr;
   logic [DW-1:0] dram_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   video_dram_slotter #(.AW(AW), .DW(DW), .PEND(7)) dut (
      .clk_i(clk), .rst_i(rst), .dram_stb_i(dram_stb), .line_start_i(line_start),
      .vid_go_i(vid_go), .video_bw_i(video_bw), .vid_req_i(vid_req),
      .video_addr_i(video_addr), .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr),
      .cpu_rnw_i(cpu_rnw), .cpu_wdata_i(cpu_wdata),
      .dram_req_o(dram_req), .dram_addr_o(dram_addr), .dram_rnw_o(dram_rnw),
      .dram_wdata_o(dram_wdata), .dram_vid_o(dram_vid), .vid_next_o(vid_next),
      .cpu_ack_o(cpu_ack), .vid_late_o(vid_late)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_vreq(input int n);
      for (int i = 0; i < n; i++) begin
         vid_req = 1'b1; tick();
         vid_req = 1'b0; tick();
      end
   endtask

   task automatic pulse_line();
      line_start = 1'b1; tick();
      line_start = 1'b0;
   endtask

   // One slot: strobe for a clk, sample the command, then confirm the pulses
   // drop and the command holds on the following clk.
   task automatic slot(output logic req, output logic vid, output logic nxt,
                       output logic ack, output logic late, output logic held_ok);
      dram_stb = 1'b1; tick();
      dram_stb = 1'b0;
      req = dram_req; vid = dram_vid; nxt = vid_next; ack = cpu_ack; late = vid_late;
      tick();
      held_ok = (dram_req == req) && (dram_vid == vid) && !vid_next && !cpu_ack && !vid_late;
      tick();
   endtask

   logic r, v, nx, ak, lt, ho;
   int   acks, nexts, lates, reqs, bad_hold;
   logic [7:0] vpat, lpat;

   initial begin
      rst = 1'b1; dram_stb = 1'b0; line_start = 1'b0; vid_go = 1'b0; vid_req = 1'b0;
      cpu_req = 1'b0; cpu_rnw = 1'b1; video_bw = 5'b0;
      video_addr = 21'h12345; cpu_addr = 21'h00ABC; cpu_wdata = 16'hBEEF;
      repeat (3) tick();
      check("rst_req",   {31'd0, dram_req}, 32'd0);
      check("rst_vid",   {31'd0, dram_vid}, 32'd0);
      check("rst_addr",  {11'd0, dram_addr}, 32'd0);
      check("rst_pulses", {29'd0, vid_next, cpu_ack, vid_late}, 32'd0);
      rst = 1'b0; tick();

      // 8-slot window, quota 1, CPU always asking
      video_bw = 5'b11_001; vid_go = 1'b1; cpu_rnw = 1'b0;
      pulse_vreq(1);
      cpu_req = 1'b1;
      acks = 0; nexts = 0; vpat = '0; bad_hold = 0;
      for (int i = 0; i < 8; i++) begin
         slot(r, v, nx, ak, lt, ho);
         acks += int'(ak); nexts += int'(nx);
         vpat = {vpat[6:0], v};
         if (!ho || !r || lt) bad_hold++;
         if (i == 0) begin
            check("t1_vaddr", {11'd0, dram_addr}, {11'd0, 21'h12345});
            check("t1_vrnw",  {31'd0, dram_rnw}, 32'd1);
         end
         if (i == 1) begin
            check("t1_caddr", {11'd0, dram_addr}, {11'd0, 21'h00ABC});
            check("t1_crnw",  {31'd0, dram_rnw}, 32'd0);
            check("t1_wdata", {16'd0, dram_wdata}, {16'd0, 16'hBEEF});
         end
      end
      cpu_req = 1'b0;
      check("t1_vpat",  {24'd0, vpat}, 32'h80);
      check("t1_acks",  acks, 32'd7);
      check("t1_nexts", nexts, 32'd1);
      check("t1_hold",  bad_hold, 32'd0);
      check("t1_wcnt",  {29'd0, dut.win_cnt_q}, 32'd0);

      // 2-slot window, quota 1, one fetch per window, CPU idle
      video_bw = 5'b00_001;
      vpat = '0; lates = 0;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) pulse_vreq(1);
         slot(r, v, nx, ak, lt, ho);
         vpat = {vpat[6:0], r};
         lates += int'(lt);
      end
      check("t2_reqpat", {24'd0, vpat}, 32'h0A);
      check("t2_late",   lates, 32'd0);

      // 8-slot window, quota 4, six fetches queued
      video_bw = 5'b11_100;
      pulse_vreq(6);
      vpat = '0; lpat = '0; reqs = 0;
      for (int i = 0; i < 8; i++) begin
         slot(r, v, nx, ak, lt, ho);
         vpat = {vpat[6:0], v};
         lpat = {lpat[6:0], lt};
         reqs += int'(r);
      end
      check("t3_vidpat",  {24'd0, vpat}, 32'hF0);
      check("t3_latepat", {24'd0, lpat}, 32'h01);
      check("t3_reqs",    reqs, 32'd4);
      check("t3_pend",    {29'd0, dut.vid_pend_q}, 32'd2);
      check("t3_idleaddr", {11'd0, dram_addr}, {11'd0, 21'h12345});
      pulse_line();
      check("t3_lsclr",   {29'd0, dut.vid_pend_q}, 32'd0);

      // increment and grant in the same clk leave the count alone
      pulse_vreq(3);
      dram_stb = 1'b1; vid_req = 1'b1; tick();
      dram_stb = 1'b0; vid_req = 1'b0;
      check("t4_grant",  {31'd0, dram_vid}, 32'd1);
      check("t4_pend3",  {29'd0, dut.vid_pend_q}, 32'd3);
      tick();
      pulse_line();
      vid_go = 1'b0;
      pulse_vreq(10);
      check("t4_sat",    {29'd0, dut.vid_pend_q}, 32'd7);
      slot(r, v, nx, ak, lt, ho);
      check("t4_nogo",   {30'd0, r, v}, 32'd0);
      pulse_line();

      // window size change mid-window takes effect at the next window
      video_bw = 5'b11_001; cpu_req = 1'b1;
      for (int i = 0; i < 3; i++) slot(r, v, nx, ak, lt, ho);
      check("t5_wc3",  {29'd0, dut.win_cnt_q}, 32'd3);
      video_bw = 5'b01_001;
      for (int i = 0; i < 4; i++) slot(r, v, nx, ak, lt, ho);
      check("t5_wc7",  {29'd0, dut.win_cnt_q}, 32'd7);
      slot(r, v, nx, ak, lt, ho);
      check("t5_wrap8", {29'd0, dut.win_cnt_q}, 32'd0);
      for (int i = 0; i < 3; i++) slot(r, v, nx, ak, lt, ho);
      check("t5_wc3b", {29'd0, dut.win_cnt_q}, 32'd3);
      slot(r, v, nx, ak, lt, ho);
      check("t5_wrap4", {29'd0, dut.win_cnt_q}, 32'd0);
      cpu_req = 1'b0;

      // reset during a video slot, then line_start mid-window
      video_bw = 5'b11_001; vid_go = 1'b1;
      pulse_vreq(1);
      dram_stb = 1'b1; tick();
      dram_stb = 1'b0;
      check("t6_vslot", {30'd0, dram_req, vid_next}, 32'd3);
      rst = 1'b1; tick();
      check("t6_rstreq",  {30'd0, dram_req, vid_next}, 32'd0);
      check("t6_rstpend", {29'd0, dut.vid_pend_q}, 32'd0);
      rst = 1'b0; tick();
      for (int i = 0; i < 3; i++) slot(r, v, nx, ak, lt, ho);
      check("t6_wc3", {29'd0, dut.win_cnt_q}, 32'd3);
      pulse_line();
      check("t6_lswc", {29'd0, dut.win_cnt_q}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
